// File: rtl/voice_allocator.sv
// voice_allocator: assigns incoming note-on/note-off events to a bank of FM synth voices.
//
// Each accepted event is held while a scan visits one channel per cycle. The scan looks
// for the lowest channel already sounding the same note and the lowest free channel. A
// single commit cycle then writes the chosen channel. A note-on prefers the matching
// voice, then a free voice, and otherwise steals the voice at a round-robin pointer. A
// note-off only drops the gate, so the envelope release keeps sounding.
//
// Ports
//   s_axi_aclk     : clock, rising edge
//   s_axi_aresetn  : asynchronous active-low reset
//   ev_valid       : note event present
//   ev_ready       : allocator idle and able to take an event
//   ev_note_on     : 1 = note-on, 0 = note-off
//   ev_note        : note number
//   ev_carrier_inc : carrier phase increment for the note
//   ev_mod_inc     : modulator phase increment for the note
//   carrier_out    : per-channel carrier increments, channel k at [k*NUM_BITS +: NUM_BITS]
//   modulator_out  : per-channel modulator increments, packed like carrier_out
//   gate           : per-channel key-down flag
//   steal_pulse    : one-cycle strobe when a sounding voice is stolen
module voice_allocator #(
   parameter int unsigned NUM_CHANNELS = 16,
   parameter int unsigned NUM_BITS     = 32,
   parameter int unsigned NOTE_BITS    = 7
) (
   input  logic                             s_axi_aclk,
   input  logic                             s_axi_aresetn,
   input  logic                             ev_valid,
   output logic                             ev_ready,
   input  logic                             ev_note_on,
   input  logic [NOTE_BITS-1:0]             ev_note,
   input  logic [NUM_BITS-1:0]              ev_carrier_inc,
   input  logic [NUM_BITS-1:0]              ev_mod_inc,
   output logic [NUM_CHANNELS*NUM_BITS-1:0] carrier_out,
   output logic [NUM_CHANNELS*NUM_BITS-1:0] modulator_out,
   output logic [NUM_CHANNELS-1:0]          gate,
   output logic                             steal_pulse
);

   localparam int unsigned ChW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
   typedef logic [ChW-1:0] ch_t;
   localparam ch_t LastCh = ch_t'(NUM_CHANNELS - 1);

   typedef enum logic [1:0] {StIdle, StScan, StCommit} state_e;

   state_e                                   state_q, state_d;
   ch_t                                      idx_q, idx_d;
   logic                                     on_q, on_d;
   logic [NOTE_BITS-1:0]                     note_q, note_d;
   logic [NUM_BITS-1:0]                      car_q, car_d;
   logic [NUM_BITS-1:0]                      mod_q, mod_d;
   logic                                     match_vld_q, match_vld_d;
   ch_t                                      match_ch_q, match_ch_d;
   logic                                     free_vld_q, free_vld_d;
   ch_t                                      free_ch_q, free_ch_d;
   logic [NUM_CHANNELS-1:0][NUM_BITS-1:0]    carrier_q, carrier_d;
   logic [NUM_CHANNELS-1:0][NUM_BITS-1:0]    modulator_q, modulator_d;
   logic [NUM_CHANNELS-1:0]                  gate_q, gate_d;
   logic [NUM_CHANNELS-1:0][NOTE_BITS-1:0]   notes_q, notes_d;
   ch_t                                      ptr_q, ptr_d;
   logic                                     steal_q, steal_d;
   ch_t                                      target;

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      on_d        = on_q;
      note_d      = note_q;
      car_d       = car_q;
      mod_d       = mod_q;
      match_vld_d = match_vld_q;
      match_ch_d  = match_ch_q;
      free_vld_d  = free_vld_q;
      free_ch_d   = free_ch_q;
      carrier_d   = carrier_q;
      modulator_d = modulator_q;
      gate_d      = gate_q;
      notes_d     = notes_q;
      ptr_d       = ptr_q;
      steal_d     = 1'b0;
      target      = ptr_q;

      case (state_q)
         StIdle: begin
            if (ev_valid) begin
               on_d        = ev_note_on;
               note_d      = ev_note;
               car_d       = ev_carrier_inc;
               mod_d       = ev_mod_inc;
               idx_d       = '0;
               match_vld_d = 1'b0;
               free_vld_d  = 1'b0;
               state_d     = StScan;
            end
         end
         StScan: begin
            // Ascending scan: the first hit recorded is the lowest index.
            if (gate_q[idx_q] && (notes_q[idx_q] == note_q) && !match_vld_q) begin
               match_vld_d = 1'b1;
               match_ch_d  = idx_q;
            end
            if (!gate_q[idx_q] && !free_vld_q) begin
               free_vld_d = 1'b1;
               free_ch_d  = idx_q;
            end
            if (idx_q == LastCh) begin
               state_d = StCommit;
            end else begin
               idx_d = idx_q + ch_t'(1);
            end
         end
         StCommit: begin
            state_d = StIdle;
            if (on_q) begin
               if (match_vld_q) begin
                  target = match_ch_q;
               end else if (free_vld_q) begin
                  target = free_ch_q;
               end else begin
                  target  = ptr_q;
                  steal_d = 1'b1;
                  ptr_d   = (ptr_q == LastCh) ? '0 : ptr_q + ch_t'(1);
               end
               carrier_d[target]   = car_q;
               modulator_d[target] = mod_q;
               notes_d[target]     = note_q;
               gate_d[target]      = 1'b1;
            end else if (match_vld_q) begin
               // Increments stay so the release tail keeps its pitch.
               gate_d[match_ch_q] = 1'b0;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         state_q     <= StIdle;
         idx_q       <= '0;
         on_q        <= 1'b0;
         note_q      <= '0;
         car_q       <= '0;
         mod_q       <= '0;
         match_vld_q <= 1'b0;
         match_ch_q  <= '0;
         free_vld_q  <= 1'b0;
         free_ch_q   <= '0;
         carrier_q   <= '0;
         modulator_q <= '0;
         gate_q      <= '0;
         notes_q     <= '0;
         ptr_q       <= '0;
         steal_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         on_q        <= on_d;
         note_q      <= note_d;
         car_q       <= car_d;
         mod_q       <= mod_d;
         match_vld_q <= match_vld_d;
         match_ch_q  <= match_ch_d;
         free_vld_q  <= free_vld_d;
         free_ch_q   <= free_ch_d;
         carrier_q   <= carrier_d;
         modulator_q <= modulator_d;
         gate_q      <= gate_d;
         notes_q     <= notes_d;
         ptr_q       <= ptr_d;
         steal_q     <= steal_d;
      end
   end

   assign ev_ready      = (state_q == StIdle);
   assign carrier_out   = carrier_q;
   assign modulator_out = modulator_q;
   assign gate          = gate_q;
   assign steal_pulse   = steal_q;

endmodule
